// File: rtl/shift_rotate_pkg.sv
// Shared opcode encodings for the shift/rotate unit.
// Every 3-bit code is assigned, so decode never needs an X fallback.
package shift_rotate_pkg;

    localparam int WIDTH_DEF = 8;

    localparam logic [2:0] OP_SHL  = 3'b000;
    localparam logic [2:0] OP_SHR  = 3'b001;
    localparam logic [2:0] OP_ROL  = 3'b010;
    localparam logic [2:0] OP_ROR  = 3'b011;
    localparam logic [2:0] OP_ASR  = 3'b100;
    localparam logic [2:0] OP_ASL  = 3'b101;
    localparam logic [2:0] OP_PASS = 3'b110;
    localparam logic [2:0] OP_RSVD = 3'b111;

endpackage

// File: rtl/shift_rotate_core.sv
// Combinational 1-bit shift/rotate datapath: (a, opcode) -> next result.
// WIDTH must be at least 2 so that the a[WIDTH-2:0] slices exist.
module shift_rotate_core
    import shift_rotate_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] a,
    input  logic [2:0]       opcode,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = '0;
        case (opcode)
            OP_SHL:  y = {a[WIDTH-2:0], 1'b0};
            OP_SHR:  y = {1'b0, a[WIDTH-1:1]};
            OP_ROL:  y = {a[WIDTH-2:0], a[WIDTH-1]};
            OP_ROR:  y = {a[0], a[WIDTH-1:1]};
            OP_ASR:  y = {a[WIDTH-1], a[WIDTH-1:1]};
            // ASL deliberately matches SHL: no overflow detection or sign saturation.
            OP_ASL:  y = {a[WIDTH-2:0], 1'b0};
            OP_PASS: y = a;
            OP_RSVD: y = '0;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/shift_rotate.sv
// Single-cycle shift/rotate unit: combinational core followed by one output register.
// Downstream samples result directly; there is no valid/ready handshake on this block.
module shift_rotate
    import shift_rotate_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [2:0]       opcode,
    output logic [WIDTH-1:0] result
);

    logic [WIDTH-1:0] w_next;
    logic [WIDTH-1:0] r_result;

    shift_rotate_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a      (a),
        .opcode (opcode),
        .y      (w_next)
    );

    // Async clear drops any value computed before reset was asserted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result <= '0;
        end else begin
            r_result <= w_next;
        end
    end

    assign result = r_result;

endmodule

// File: tb/tb_shift_rotate.sv
// Self-checking bench for shift_rotate: directed vectors plus randomized opcodes
// scored against an arithmetic reference model through an expected-value queue.
module tb_shift_rotate;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] a;
    logic [2:0]   opcode;
    logic [W-1:0] result;

    int n_tests = 0;
    int n_fail  = 0;
    logic [W-1:0] exp_q[$];

    shift_rotate #(
        .WIDTH (W)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .a      (a),
        .opcode (opcode),
        .result (result)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Works on integer values: doubling, halving and adding back wrapped bits.
    function automatic logic [W-1:0] ref_model(input logic [W-1:0] av, input logic [2:0] op);
        int v;
        int top;
        int r;
        v   = int'(av);
        top = 1 << (W - 1);
        case (op)
            3'd0:    r = (v * 2) % (2 * top);
            3'd1:    r = v / 2;
            3'd2:    r = (v * 2) % (2 * top) + v / top;
            3'd3:    r = v / 2 + (v % 2) * top;
            3'd4:    r = v / 2 + ((v >= top) ? top : 0);
            3'd5:    r = (v * 2) % (2 * top);
            3'd6:    r = v;
            default: r = 0;
        endcase
        return r[W-1:0];
    endfunction

    // ---------------- checker ----------------
    task automatic check_val(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- driver ----------------
    // Called just after an active edge; applies inputs, then checks one edge later.
    task automatic drive_op(input string tag, input logic [W-1:0] av, input logic [2:0] op,
                            input logic [W-1:0] exp);
        logic [W-1:0] e;
        a      = av;
        opcode = op;
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: scoreboard queue empty", tag);
        end else begin
            e = exp_q.pop_front();
            check_val(tag, result, e);
        end
    endtask

    // ---------------- stimulus ----------------
    logic [W-1:0] sweep_exp [8];
    logic [W-1:0] ra;
    logic [2:0]   rop;

    initial begin
        sweep_exp[0] = 8'b01101010;
        sweep_exp[1] = 8'b01011010;
        sweep_exp[2] = 8'b01101011;
        sweep_exp[3] = 8'b11011010;
        sweep_exp[4] = 8'b11011010;
        sweep_exp[5] = 8'b01101010;
        sweep_exp[6] = 8'b10110101;
        sweep_exp[7] = 8'b00000000;

        rst_n  = 1'b1;
        a      = 8'hFF;
        opcode = 3'b110;

        // Async reset, asserted between edges.
        #1;
        rst_n = 1'b0;
        #1;
        check_val("reset_immediate", result, 8'h00);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_val("reset_hold", result, 8'h00);
        end
        rst_n = 1'b1;

        // Release: first edge loads f(a, opcode).
        drive_op("release_pass", 8'hFF, 3'b110, 8'hFF);

        // Opcode sweep on 10110101.
        for (int op = 0; op < 8; op++) begin
            drive_op($sformatf("sweep_op%0d", op), 8'b10110101, 3'(op), sweep_exp[op]);
        end

        // Positive operand for ASR / ROR.
        drive_op("asr_pos", 8'b01000001, 3'b100, 8'b00100000);
        drive_op("ror_pos", 8'b01000001, 3'b011, 8'b10100000);

        // Edge values.
        for (int op = 0; op < 8; op++) begin
            drive_op($sformatf("zero_op%0d", op), 8'h00, 3'(op), 8'h00);
        end
        drive_op("ff_shl",  8'hFF, 3'b000, 8'hFE);
        drive_op("ff_shr",  8'hFF, 3'b001, 8'h7F);
        drive_op("ff_rol",  8'hFF, 3'b010, 8'hFF);
        drive_op("ff_ror",  8'hFF, 3'b011, 8'hFF);
        drive_op("ff_asr",  8'hFF, 3'b100, 8'hFF);
        drive_op("ff_asl",  8'hFF, 3'b101, 8'hFE);
        drive_op("ff_pass", 8'hFF, 3'b110, 8'hFF);
        drive_op("ff_rsvd", 8'hFF, 3'b111, 8'h00);

        // Mid-operation reset: result is nonzero (FF), then pulsed low between edges.
        drive_op("pre_midreset", 8'hFF, 3'b110, 8'hFF);
        a      = 8'h81;
        opcode = 3'b010;
        #2;
        rst_n = 1'b0;
        #1;
        check_val("midreset_clear", result, 8'h00);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_val("midreset_release", result, 8'h03);

        // Back-to-back random traffic, opcode changes every cycle.
        rop = 3'($urandom_range(0, 7));
        for (int i = 0; i < 48; i++) begin
            ra  = W'($urandom_range(0, 255));
            rop = rop + 3'($urandom_range(1, 7));
            drive_op($sformatf("rand%0d_op%0d", i, rop), ra, rop, ref_model(ra, rop));
        end

        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_leftover: got %0d entries expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Hard time limit so the bench always terminates.
    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $finish;
    end

endmodule
